// File: rtl/winograd_tile_scheduler.sv
// Winograd tile scheduler: fetches 6x6 input tiles, hands them to a tile controller and writes
// back the 4x4 results. Define WINO_SCHED_PERF_EN to build the job cycle counter.
module winograd_tile_scheduler #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  input  logic [15:0]                   img_rows,
  input  logic [15:0]                   img_cols,
  output logic                          rd_en,
  output logic [ADDR_W-1:0]             rd_addr,
  input  logic [DATA_W-1:0]             rd_data,
  output logic                          tc_start,
  input  logic                          tc_done,
  output logic [0:5][0:5][DATA_W-1:0]   tile_out,
  input  logic [0:3][0:3][DATA_W-1:0]   result_in,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [DATA_W-1:0]             wr_data,
  output logic [31:0]                   perf_cycles
);

  typedef enum logic [2:0] {StIdle, StFetch, StCompute, StWait, StWrite, StDone} state_e;

  state_e                        state_q, state_d;
  logic [15:0]                   cols_q, out_cols_q, tiles_r_q, tiles_c_q, tr_q, tc_q;
  logic [2:0]                    i_q, j_q, cap_i_q, cap_j_q;
  logic                          drain_q, cap_vld_q, err_q;
  logic [0:5][0:5][DATA_W-1:0]   tile_q;
  logic [0:3][0:3][DATA_W-1:0]   result_q;

  logic                          dims_ok, accept, last_tile;
  logic [31:0]                   row0, col0;
  logic [ADDR_W-1:0]             rd_addr_calc, wr_addr_calc;

  assign dims_ok = (img_rows >= 16'd6) && (img_cols >= 16'd6) &&
                   (img_rows[1:0] == 2'd2) && (img_cols[1:0] == 2'd2);
  assign accept  = (state_q == StIdle) && start && dims_ok;

  assign row0 = {14'd0, tr_q, 2'd0};
  assign col0 = {14'd0, tc_q, 2'd0};
  assign rd_addr_calc = ADDR_W'((row0 + 32'(i_q)) * {16'd0, cols_q} + col0 + 32'(j_q));
  assign wr_addr_calc = ADDR_W'((row0 + 32'(i_q)) * {16'd0, out_cols_q} + col0 + 32'(j_q));
  assign last_tile = (tr_q == tiles_r_q - 16'd1) && (tc_q == tiles_c_q - 16'd1);

  assign tile_out = tile_q;
  assign err      = err_q;

  always_comb begin
    state_d  = state_q;
    busy     = (state_q != StIdle);
    done     = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    tc_start = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StFetch;
      end
      StFetch: begin
        // Final FETCH cycle only drains the last read's data into the tile.
        if (drain_q) begin
          state_d = StCompute;
        end else begin
          rd_en   = 1'b1;
          rd_addr = rd_addr_calc;
        end
      end
      StCompute: begin
        tc_start = 1'b1;
        state_d  = StWait;
      end
      StWait: begin
        if (tc_done) state_d = StWrite;
      end
      StWrite: begin
        wr_en   = 1'b1;
        wr_addr = wr_addr_calc;
        wr_data = result_q[i_q[1:0]][j_q[1:0]];
        if (i_q == 3'd3 && j_q == 3'd3) state_d = last_tile ? StDone : StFetch;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cols_q     <= '0;
      out_cols_q <= '0;
      tiles_r_q  <= '0;
      tiles_c_q  <= '0;
      tr_q       <= '0;
      tc_q       <= '0;
      i_q        <= '0;
      j_q        <= '0;
      cap_i_q    <= '0;
      cap_j_q    <= '0;
      drain_q    <= 1'b0;
      cap_vld_q  <= 1'b0;
      err_q      <= 1'b0;
      tile_q     <= '0;
      result_q   <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= (state_q == StIdle) && start && !dims_ok;
      cap_vld_q <= rd_en;
      cap_i_q   <= i_q;
      cap_j_q   <= j_q;
      if (cap_vld_q) tile_q[cap_i_q][cap_j_q] <= rd_data;
      if (state_q == StWait && tc_done) result_q <= result_in;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            cols_q     <= img_cols;
            out_cols_q <= img_cols - 16'd2;
            tiles_r_q  <= (img_rows - 16'd2) >> 2;
            tiles_c_q  <= (img_cols - 16'd2) >> 2;
            tr_q       <= '0;
            tc_q       <= '0;
            i_q        <= '0;
            j_q        <= '0;
            drain_q    <= 1'b0;
          end
        end
        StFetch: begin
          if (!drain_q) begin
            if (j_q == 3'd5) begin
              j_q <= '0;
              if (i_q == 3'd5) begin
                i_q     <= '0;
                drain_q <= 1'b1;
              end else begin
                i_q <= i_q + 3'd1;
              end
            end else begin
              j_q <= j_q + 3'd1;
            end
          end
        end
        StWrite: begin
          if (j_q == 3'd3) begin
            j_q <= '0;
            if (i_q == 3'd3) begin
              i_q     <= '0;
              drain_q <= 1'b0;
              if (tc_q == tiles_c_q - 16'd1) begin
                tc_q <= '0;
                tr_q <= tr_q + 16'd1;
              end else begin
                tc_q <= tc_q + 16'd1;
              end
            end else begin
              i_q <= i_q + 3'd1;
            end
          end else begin
            j_q <= j_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WINO_SCHED_PERF_EN
  logic [31:0] perf_q;

  // Counting stops once back in IDLE, so the value holds until the next accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if (accept) begin
      perf_q <= '0;
    end else if (busy) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_winograd_tile_scheduler.sv
// Directed bench for winograd_tile_scheduler with an image-memory and tile-controller model.
module tb_winograd_tile_scheduler;
  localparam int DW = 32;
  localparam int AW = 16;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        start = 1'b0;
  logic                        busy, done, err;
  logic [15:0]                 img_rows = '0, img_cols = '0;
  logic                        rd_en;
  logic [AW-1:0]               rd_addr;
  logic [DW-1:0]               rd_data = '0;
  logic                        tc_start;
  logic                        tc_done = 1'b0;
  logic [0:5][0:5][DW-1:0]     tile_out;
  logic [0:3][0:3][DW-1:0]     result_in = '0;
  logic                        wr_en;
  logic [AW-1:0]               wr_addr;
  logic [DW-1:0]               wr_data;
  logic [31:0]                 perf_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] rd_log[$];
  logic [AW-1:0] wr_alog[$];
  logic [DW-1:0] wr_dlog[$];
  int tcs_cnt, done_cnt, err_cnt, busy_cnt, first_busy, tile_unstable;

  winograd_tile_scheduler #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .img_rows(img_rows), .img_cols(img_cols), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .tc_start(tc_start), .tc_done(tc_done), .tile_out(tile_out),
    .result_in(result_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  // Drives one job: memory returns addr+1 a cycle after each read, the tile controller answers
  // 5 cycles after tc_start with result[i][j] = tile[i+1][j+1].
  task automatic run_job(input logic [15:0] rows, input logic [15:0] cols, input int max_cyc,
                         input bit poke, input int rst_at);
    logic                    pend;
    logic [AW-1:0]           paddr;
    int                      wcnt;
    logic [0:5][0:5][DW-1:0] snap;
    pend = 1'b0; paddr = '0; wcnt = 0; snap = '0;
    rd_log.delete(); wr_alog.delete(); wr_dlog.delete();
    tcs_cnt = 0; done_cnt = 0; err_cnt = 0; busy_cnt = 0; first_busy = -1; tile_unstable = 0;
    @(negedge clk);
    rst_n = 1'b1; img_rows = rows; img_cols = cols; start = 1'b1;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk);
      start   = 1'b0;
      rd_data = pend ? ({16'd0, paddr} + 32'd1) : 32'd0;
      pend    = rd_en;
      paddr   = rd_addr;
      if (rd_en) rd_log.push_back(rd_addr);
      if (wr_en) begin
        wr_alog.push_back(wr_addr);
        wr_dlog.push_back(wr_data);
      end
      if (tc_start) begin
        tcs_cnt++;
        snap = tile_out;
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = cyc;
      end
      if (wcnt > 0 && tile_out !== snap) tile_unstable++;
      tc_done = 1'b0;
      if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0) begin
          tc_done = 1'b1;
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) result_in[i][j] = tile_out[i+1][j+1];
        end
      end
      if (tc_start) wcnt = 5;
      if (poke && busy && ((rd_en && rd_log.size() == 10) || wcnt == 3)) begin
        start = 1'b1; img_rows = 16'd10; img_cols = 16'd10;
      end
      if (rst_at != 0 && rd_en && rd_log.size() == rst_at) begin
        rst_n = 1'b0;
        break;
      end
      if (done_cnt != 0) break;
    end
    tc_done = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, done, err, rd_en, tc_start, wr_en} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000",
                         {busy, done, err, rd_en, tc_start, wr_en});
    end
    n_tests++;
    if ({rd_addr, wr_addr, wr_data} !== '0) begin
      n_fail++; $display("FAIL reset_bus: got rd %0d wr %0d data %0d expected 0", rd_addr,
                         wr_addr, wr_data);
    end
    n_tests++;
    if (tile_out !== '0 || perf_cycles !== 32'd0) begin
      n_fail++; $display("FAIL reset_tile_perf: got perf %0d expected 0 with zero tile",
                         perf_cycles);
    end
  endtask

  task automatic test_single_tile;
    int bad;
    logic [31:0] perf_exp;
    run_job(16'd6, 16'd6, 300, 1'b0, 0);
    n_tests++;
    if (first_busy !== 0) begin
      n_fail++; $display("FAIL first_start: busy first at cycle %0d expected 0", first_busy);
    end
    n_tests++;
    if (done_cnt !== 1 || tcs_cnt !== 1) begin
      n_fail++; $display("FAIL single_pulses: done %0d tc_start %0d expected 1 1", done_cnt,
                         tcs_cnt);
    end
    bad = 0;
    for (int k = 0; k < rd_log.size(); k++) if (rd_log[k] !== 16'(k)) bad++;
    n_tests++;
    if (rd_log.size() !== 36 || bad !== 0) begin
      n_fail++; $display("FAIL single_rd: %0d reads %0d wrong expected 36 reads 0 wrong",
                         rd_log.size(), bad);
    end
    bad = 0;
    for (int k = 0; k < wr_alog.size(); k++) begin
      if (wr_alog[k] !== 16'(k)) bad++;
      if (wr_dlog[k] !== 32'(6 * (k / 4) + (k % 4) + 8)) bad++;
    end
    n_tests++;
    if (wr_alog.size() !== 16 || bad !== 0) begin
      n_fail++; $display("FAIL single_wr: %0d writes %0d wrong expected 16 writes 0 wrong",
                         wr_alog.size(), bad);
    end
    n_tests++;
    if (tile_unstable !== 0) begin
      n_fail++; $display("FAIL tile_stable: %0d changes expected 0", tile_unstable);
    end
    n_tests++;
    if (busy_cnt !== 60) begin
      n_fail++; $display("FAIL single_latency: busy %0d cycles expected 60", busy_cnt);
    end
`ifdef WINO_SCHED_PERF_EN
    perf_exp = 32'(busy_cnt);
`else
    perf_exp = 32'd0;
`endif
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || perf_cycles !== perf_exp) begin
      n_fail++; $display("FAIL single_after: busy %b done %b perf %0d expected 0 0 %0d", busy,
                         done, perf_cycles, perf_exp);
    end
  endtask

  task automatic test_multi_tile;
    int bad, t, i, j;
    run_job(16'd10, 16'd10, 1000, 1'b0, 0);
    n_tests++;
    if (tcs_cnt !== 4 || done_cnt !== 1) begin
      n_fail++; $display("FAIL multi_pulses: tc_start %0d done %0d expected 4 1", tcs_cnt,
                         done_cnt);
    end
    n_tests++;
    if (rd_log.size() !== 144 || wr_alog.size() !== 64) begin
      n_fail++; $display("FAIL multi_counts: reads %0d writes %0d expected 144 64",
                         rd_log.size(), wr_alog.size());
    end else begin
      n_tests++;
      if (rd_log[0] !== 16'd0 || rd_log[36] !== 16'd4 || rd_log[72] !== 16'd40 ||
          rd_log[108] !== 16'd44) begin
        n_fail++; $display("FAIL multi_rd_first: got %0d %0d %0d %0d expected 0 4 40 44",
                           rd_log[0], rd_log[36], rd_log[72], rd_log[108]);
      end
      n_tests++;
      if (wr_alog[0] !== 16'd0 || wr_alog[16] !== 16'd4 || wr_alog[32] !== 16'd32 ||
          wr_alog[48] !== 16'd36) begin
        n_fail++; $display("FAIL multi_wr_first: got %0d %0d %0d %0d expected 0 4 32 36",
                           wr_alog[0], wr_alog[16], wr_alog[32], wr_alog[48]);
      end
      bad = 0;
      for (int k = 0; k < 144; k++) begin
        t = k / 36; i = (k % 36) / 6; j = k % 6;
        if (rd_log[k] !== 16'((4 * (t / 2) + i) * 10 + 4 * (t % 2) + j)) bad++;
      end
      for (int k = 0; k < 64; k++) begin
        t = k / 16; i = (k % 16) / 4; j = k % 4;
        if (wr_alog[k] !== 16'((4 * (t / 2) + i) * 8 + 4 * (t % 2) + j)) bad++;
        if (wr_dlog[k] !== 32'((4 * (t / 2) + i + 1) * 10 + 4 * (t % 2) + j + 2)) bad++;
      end
      n_tests++;
      if (bad !== 0) begin
        n_fail++; $display("FAIL multi_seq: %0d wrong entries expected 0", bad);
      end
    end
  endtask

  task automatic test_bad_dims;
    run_job(16'd7, 16'd6, 6, 1'b0, 0);
    n_tests++;
    if (err_cnt !== 1 || busy_cnt !== 0 || rd_log.size() !== 0) begin
      n_fail++; $display("FAIL bad_rows: err %0d busy %0d reads %0d expected 1 0 0", err_cnt,
                         busy_cnt, rd_log.size());
    end
    run_job(16'd6, 16'd3, 6, 1'b0, 0);
    n_tests++;
    if (err_cnt !== 1 || busy_cnt !== 0 || rd_log.size() !== 0) begin
      n_fail++; $display("FAIL bad_cols: err %0d busy %0d reads %0d expected 1 0 0", err_cnt,
                         busy_cnt, rd_log.size());
    end
  endtask

  task automatic test_start_ignored;
    int bad;
    run_job(16'd6, 16'd6, 300, 1'b1, 0);
    bad = 0;
    for (int k = 0; k < rd_log.size(); k++) if (rd_log[k] !== 16'(k)) bad++;
    for (int k = 0; k < wr_alog.size(); k++) if (wr_alog[k] !== 16'(k)) bad++;
    n_tests++;
    if (rd_log.size() !== 36 || wr_alog.size() !== 16 || bad !== 0 || done_cnt !== 1 ||
        tcs_cnt !== 1 || err_cnt !== 0) begin
      n_fail++; $display("FAIL start_ignored: rd %0d wr %0d bad %0d done %0d tc %0d err %0d expected 36 16 0 1 1 0",
                         rd_log.size(), wr_alog.size(), bad, done_cnt, tcs_cnt, err_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int bad;
    run_job(16'd6, 16'd6, 300, 1'b0, 20);
    @(negedge clk);
    n_tests++;
    if (rd_log.size() !== 20 || {busy, done, err, rd_en, tc_start, wr_en} !== 6'b0 ||
        {rd_addr, wr_addr, wr_data} !== '0 || tile_out !== '0 || perf_cycles !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid: reads %0d ctrl %b rd %0d expected 20 000000 0",
                         rd_log.size(), {busy, done, err, rd_en, tc_start, wr_en}, rd_addr);
    end
    run_job(16'd6, 16'd6, 300, 1'b0, 0);
    bad = 0;
    for (int k = 0; k < rd_log.size(); k++) if (rd_log[k] !== 16'(k)) bad++;
    for (int k = 0; k < wr_dlog.size(); k++)
      if (wr_dlog[k] !== 32'(6 * (k / 4) + (k % 4) + 8)) bad++;
    n_tests++;
    if (rd_log.size() !== 36 || wr_dlog.size() !== 16 || bad !== 0 || done_cnt !== 1) begin
      n_fail++; $display("FAIL reset_rerun: rd %0d wr %0d bad %0d done %0d expected 36 16 0 1",
                         rd_log.size(), wr_dlog.size(), bad, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_bad_dims();
    test_start_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/winograd_tile_scheduler.md
WINOGRAD_TILE_SCHEDULER -- requirements
Module: winograd_tile_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the element width.
REQ-002 SHALL have parameter ADDR_W, default 16, the width of both memory addresses.
REQ-003 SHALL have port clk  in  1  single clock.
REQ-004 SHALL have port rst_n  in  1  reset: synchronous, active-low.
REQ-005 SHALL have port start / busy / done / err  in / out / out / out  1 each: job request / job active / job-complete pulse / bad-dimension pulse.
REQ-006 SHALL have port img_rows, img_cols  in  16 each: input image size, sampled on an accepted start.
REQ-007 SHALL have port rd_en  out  1, rd_addr  out  ADDR_W, rd_data  in  DATA_W: image read port with 1-cycle read latency.
REQ-008 SHALL have port tc_start  out  1, tc_done  in  1, tile_out  out  DATA_W x [0:5][0:5], result_in  in  DATA_W x [0:3][0:3]: tile_controller initiator side.
REQ-009 SHALL have port wr_en  out  1, wr_addr  out  ADDR_W, wr_data  out  DATA_W: result write port.
REQ-010 SHALL have port perf_cycles  out  32: job cycle count (see Configuration).

Function
REQ-011 SHALL implement FSM states IDLE, FETCH, COMPUTE, WAIT, WRITE, DONE.
REQ-012 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-013 SHALL treat dimensions as valid only when rows>=6, cols>=6, (rows-2)%4==0 and (cols-2)%4==0; an invalid start SHALL pulse err for 1 cycle and stay in IDLE.
REQ-014 SHALL define out_cols=cols-2, tiles_r=(rows-2)/4, tiles_c=(cols-2)/4, and visit tiles row-major with origin (4*tr, 4*tc).
REQ-015 FETCH SHALL assert rd_en for 36 consecutive cycles with rd_addr=(r0+i)*cols+(c0+j), i,j in 0..5 row-major; each rd_data SHALL be captured into tile_out[i][j] on the cycle after its read.
REQ-016 SHALL enter COMPUTE the cycle after the 36th capture and assert tc_start for exactly that single cycle, then enter WAIT.
REQ-017 WAIT SHALL hold until tc_done is sampled high; tile_out SHALL stay stable from COMPUTE until WAIT is exited.
REQ-018 On leaving WAIT, SHALL latch result_in; WRITE SHALL assert wr_en for 16 consecutive cycles, wr_addr=(r0+i)*out_cols+(c0+j), wr_data=result[i][j], i,j in 0..3 row-major.
REQ-019 After the 16th write SHALL enter FETCH for the next tile the next cycle, or DONE after the last tile (tr=tiles_r-1, tc=tiles_c-1).
REQ-020 DONE SHALL pulse done for 1 cycle and return to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-021 Address arithmetic SHALL be truncated to ADDR_W bits; overflow is out of scope and SHALL NOT be detected.
REQ-022 rd_en, wr_en, tc_start, done and err SHALL be 0 in every cycle not named above.

Reset
REQ-023 rst_n low at a clock edge SHALL force IDLE from any state, including mid-FETCH, mid-WAIT or mid-WRITE, and abandon the current job.
REQ-024 Reset SHALL drive to 0: busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data, tc_start, every tile_out element, the tile counters and perf_cycles.
REQ-025 The first start SHALL be accepted on the first edge with rst_n high.

Configuration
REQ-026 Macro WINO_SCHED_PERF_EN defined: perf_cycles SHALL clear on an accepted start, increment each busy cycle, and hold its value from done until the next accepted start.
REQ-027 Macro WINO_SCHED_PERF_EN undefined: perf_cycles SHALL be constant 0 and no counter logic is built.

Verification
REQ-028 6x6 image, values 1..36 row-major; tc_done model returns result[i][j]=tile[i+1][j+1] after 5 cycles -> one tile, rd_addr 0..35, 16 writes to addr 0..15 with data 8,9,10,11,14.., one done pulse.
REQ-029 10x10 image -> 4 tiles; tile origins (0,0),(0,4),(4,0),(4,4); first rd_addr per tile 0,4,40,44; first wr_addr per tile 0,4,32,36; exactly 4 tc_start pulses.
REQ-030 start with 7x6 and then 6x3 dimensions -> err pulse each time, busy stays 0, no rd_en.
REQ-031 start reasserted during FETCH and WAIT -> ignored; job completes with the same address sequence as REQ-028.
REQ-032 rst_n low during the 20th FETCH cycle -> next cycle in IDLE with all outputs 0; a new 6x6 job then runs cleanly.
REQ-033 With WINO_SCHED_PERF_EN, 6x6 job with a 5-cycle tc_done model -> perf_cycles equals the measured start-to-done cycle count; without the macro -> perf_cycles 0.
